// File: rtl/dds_mod_ctrl.sv
// dds_mod_ctrl: quarter sequencer and BPSK/ASK modulator for the DDS datapath.
// Drives the P (quarter-mirror) and S (sign) controls, counts whole sine
// cycles to frame data bits, and takes serial bits through a one-entry
// valid/ready buffer. The mute output gates the sample at the top level.
// Optional feature: define DIFF_ENC_EN to differentially encode the BPSK
// phase (DBPSK); the default build is plain BPSK.
module dds_mod_ctrl #(
  parameter int CYC_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       co6,
  input  logic [1:0] mode,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic       P,
  output logic       S,
  output logic       mute,
  output logic       bit_start,
  output logic       underrun,
  output logic       cur_bit
);

  localparam logic [7:0] LAST_CYC = 8'(CYC_PER_BIT - 1);

  localparam logic [1:0] MODE_BPSK = 2'b01;
  localparam logic [1:0] MODE_ASK  = 2'b10;

  // Encoding chosen so bit 0 is P and bit 1 is the base sign.
  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b01,
    Q2 = 2'b10,
    Q3 = 2'b11
  } quarter_t;

  quarter_t   quarter;
  quarter_t   quarter_nxt;
  logic [7:0] cyc_cnt;
  logic       buf_full;
  logic       buf_bit;
  logic       phase;
  logic       sine_done;
  logic       boundary;
  logic       take;
  logic       load_bit;
  logic       s_base;

  // A co6 pulse in Q3 closes one full sine; the last one of a bit is the boundary.
  assign sine_done = co6 && (quarter == Q3);
  assign boundary  = sine_done && (cyc_cnt == LAST_CYC);
  assign take      = bit_valid && !buf_full;
  assign load_bit  = buf_full && buf_bit;

  // Quarter state register, stepping on the same edge the datapath counter wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) quarter <= Q0;
    else      quarter <= quarter_nxt;
  end

  // Next quarter: advance one step per co6 pulse, hold otherwise.
  always_comb begin
    quarter_nxt = quarter;
    if (co6) begin
      case (quarter)
        Q0:      quarter_nxt = Q1;
        Q1:      quarter_nxt = Q2;
        Q2:      quarter_nxt = Q3;
        Q3:      quarter_nxt = Q0;
        default: quarter_nxt = Q0;
      endcase
    end
  end

  // Whole-sine counter within the current bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= 8'd0;
    end else if (sine_done) begin
      if (boundary) cyc_cnt <= 8'd0;
      else          cyc_cnt <= cyc_cnt + 8'd1;
    end
  end

  // Input buffer and current bit; an empty buffer at a boundary sends a 0.
  // A write landing on a boundary edge with the buffer empty stays buffered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full  <= 1'b0;
      buf_bit   <= 1'b0;
      cur_bit   <= 1'b0;
      bit_start <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      bit_start <= boundary;
      underrun  <= boundary && !buf_full;
      if (boundary && buf_full) begin
        cur_bit  <= buf_bit;
        buf_full <= 1'b0;
      end else begin
        if (boundary) cur_bit <= 1'b0;
        if (take) begin
          buf_full <= 1'b1;
          buf_bit  <= bit_in;
        end
      end
    end
  end

`ifdef DIFF_ENC_EN
  // Differential phase: toggles on every 1 loaded at a boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          phase <= 1'b0;
    else if (boundary) phase <= phase ^ load_bit;
  end
`else
  assign phase = cur_bit;

  // load_bit only feeds the differential phase register.
  logic unused_load;
  assign unused_load = load_bit;
`endif

  assign bit_ready = ~buf_full;
  assign P         = quarter[0];
  assign s_base    = quarter[1];

  // Sign and mute per mode; purely from registers so mode changes act at once.
  always_comb begin
    S    = s_base;
    mute = 1'b0;
    case (mode)
      MODE_BPSK: S    = s_base ^ phase;
      MODE_ASK:  mute = ~cur_bit;
      default:   ;
    endcase
  end

endmodule
